// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter for eight 16-bit requesters sharing one bus.
// Grants one owner at a time, rotates on release or when the hold limit is hit
// with a competitor waiting, and registers the owner's word onto dout.
module bus_arbiter8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [7:0]  gnt,
  output logic [2:0]  sel,
  output logic        busy,
  output logic [15:0] dout,
  output logic        dout_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      r_state;
  logic [2:0]  r_ptr;
  logic [3:0]  r_holdCnt;
  logic [7:0]  r_gnt;
  logic [2:0]  r_sel;
  logic        r_busy;
  logic [15:0] r_dout;
  logic        r_doutValid;

  logic [3:0]  w_idlePick;
  logic [3:0]  w_rotPick;
  logic [2:0]  w_ownerNext;
  logic [15:0] w_word;
  logic        w_holdLimit;

  // Returns {found, index} of the first set request among span positions
  // starting at start and wrapping modulo 8.
  function automatic logic [3:0] pickFrom(input logic [7:0] reqs,
                                          input logic [2:0] start,
                                          input int         span);
    logic       found;
    logic [2:0] idx;
    logic [2:0] pos;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      pos = start + 3'(k);
      if (!found && (k < span) && reqs[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  // The rotation search starts after the owner and covers only the other
  // seven slots, so the owner itself can never be re-picked by it.
  assign w_ownerNext = r_sel + 3'd1;
  assign w_idlePick  = pickFrom(req, r_ptr, 8);
  assign w_rotPick   = pickFrom(req, w_ownerNext, 7);

  // A counter that saturated while the owner was alone still triggers
  // rotation as soon as a competitor shows up.
  assign w_holdLimit = (r_holdCnt >= 4'(MAX_HOLD - 1));

  // Word multiplexer driven by the registered owner index.
  always_comb begin
    w_word = a;
    case (r_sel)
      3'd0: w_word = a;
      3'd1: w_word = b;
      3'd2: w_word = c;
      3'd3: w_word = d;
      3'd4: w_word = e;
      3'd5: w_word = f;
      3'd6: w_word = g;
      3'd7: w_word = h;
      default: w_word = a;
    endcase
  end

  // Arbiter state machine plus the registered data path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd0;
      r_holdCnt   <= 4'd0;
      r_gnt       <= 8'd0;
      r_sel       <= 3'd0;
      r_busy      <= 1'b0;
      r_dout      <= 16'd0;
      r_doutValid <= 1'b0;
    end else begin
      r_dout      <= w_word;
      r_doutValid <= (r_state == GRANT) && req[r_sel];
      case (r_state)
        IDLE: begin
          if (w_idlePick[3]) begin
            r_state   <= GRANT;
            r_gnt     <= 8'd1 << w_idlePick[2:0];
            r_sel     <= w_idlePick[2:0];
            r_busy    <= 1'b1;
            r_holdCnt <= 4'd0;
          end
        end
        GRANT: begin
          if (!req[r_sel]) begin
            r_ptr <= w_ownerNext;
            if (w_rotPick[3]) begin
              r_gnt     <= 8'd1 << w_rotPick[2:0];
              r_sel     <= w_rotPick[2:0];
              r_holdCnt <= 4'd0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 8'd0;
              r_busy  <= 1'b0;
            end
          end else if (w_holdLimit && w_rotPick[3]) begin
            r_ptr     <= w_ownerNext;
            r_gnt     <= 8'd1 << w_rotPick[2:0];
            r_sel     <= w_rotPick[2:0];
            r_holdCnt <= 4'd0;
          end else if (r_holdCnt != 4'd15) begin
            r_holdCnt <= r_holdCnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 8'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign busy       = r_busy;
  assign dout       = r_dout;
  assign dout_valid = r_doutValid;

endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: directed bench for bus_arbiter8 with the default hold limit.
// Each step drives inputs, queues the outputs expected after the next edge,
// and compares them on the following falling edge.
module tb_bus_arbiter8;

  logic        clk;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] words [8];
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic        busy;
  logic [15:0] dout;
  logic        dout_valid;

  typedef struct {
    string       tag;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        busy;
    logic [15:0] dout;
    logic        dv;
  } expect_t;

  expect_t scoreboard [$];
  int      checkCount = 0;
  int      passCount  = 0;

  bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .a          (words[0]),
    .b          (words[1]),
    .c          (words[2]),
    .d          (words[3]),
    .e          (words[4]),
    .f          (words[5]),
    .g          (words[6]),
    .h          (words[7]),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string tag, input string name,
                            input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, name, obs, exp);
  endtask

  task automatic checkOutput();
    expect_t ex;
    if (scoreboard.size() == 0) begin
      checkCount++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    while (scoreboard.size() > 0) begin
      ex = scoreboard.pop_front();
      checkField(ex.tag, "gnt",        16'(gnt),        16'(ex.gnt));
      checkField(ex.tag, "sel",        16'(sel),        16'(ex.sel));
      checkField(ex.tag, "busy",       16'(busy),       16'(ex.busy));
      checkField(ex.tag, "dout",       dout,            ex.dout);
      checkField(ex.tag, "dout_valid", 16'(dout_valid), 16'(ex.dv));
      checkField(ex.tag, "onehot",     16'($onehot0(gnt)), 16'd1);
      checkField(ex.tag, "busyGnt",    16'(gnt != 8'd0), 16'(busy));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] reqVal, input logic rstVal,
                               input string tag, input logic [7:0] eGnt,
                               input logic [2:0] eSel, input logic eBusy,
                               input logic [15:0] eDout, input logic eDv);
    expect_t ex;
    req   = reqVal;
    reset = rstVal;
    ex.tag  = tag;
    ex.gnt  = eGnt;
    ex.sel  = eSel;
    ex.busy = eBusy;
    ex.dout = eDout;
    ex.dv   = eDv;
    scoreboard.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) words[i] = 16'hC000 + 16'(i * 16'h0101);
    words[3] = 16'h1234;
    reset = 1'b1;
    req   = 8'h00;

    // Reset for two cycles, then a lone request from requester 3.
    applyStimulus(8'h00, 1'b1, "reset0", 8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(8'h00, 1'b1, "reset1", 8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(8'h08, 1'b0, "single_gnt", 8'h08, 3'd3, 1'b1, words[0], 1'b0);
    for (int n = 0; n < 20; n++)
      applyStimulus(8'h08, 1'b0, "single_hold", 8'h08, 3'd3, 1'b1, 16'h1234, 1'b1);

    // Last owner releases, then a re-request waits exactly one cycle.
    applyStimulus(8'h00, 1'b0, "release_idle", 8'h00, 3'd3, 1'b0, 16'h1234, 1'b0);
    applyStimulus(8'h08, 1'b0, "rereq_gnt", 8'h08, 3'd3, 1'b1, 16'h1234, 1'b0);
    applyStimulus(8'h08, 1'b0, "rereq_data", 8'h08, 3'd3, 1'b1, 16'h1234, 1'b1);
    applyStimulus(8'h00, 1'b0, "release2", 8'h00, 3'd3, 1'b0, 16'h1234, 1'b0);

    // All eight requesting from a fresh pointer: four cycles per owner.
    applyStimulus(8'h00, 1'b1, "reset_rr", 8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(8'hFF, 1'b0, "rr_first", 8'h01, 3'd0, 1'b1, words[0], 1'b0);
    for (int n = 1; n < 36; n++)
      applyStimulus(8'hFF, 1'b0, "rr", 8'd1 << ((n / 4) % 8), 3'((n / 4) % 8),
                    1'b1, words[((n - 1) / 4) % 8], 1'b1);

    // Early release of owner 2 with requester 5 waiting.
    applyStimulus(8'h00, 1'b1, "reset_er", 8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(8'h24, 1'b0, "er_gnt2", 8'h04, 3'd2, 1'b1, words[0], 1'b0);
    applyStimulus(8'h24, 1'b0, "er_hold2", 8'h04, 3'd2, 1'b1, words[2], 1'b1);
    applyStimulus(8'h20, 1'b0, "er_hand5", 8'h20, 3'd5, 1'b1, words[2], 1'b0);
    applyStimulus(8'h20, 1'b0, "er_data5", 8'h20, 3'd5, 1'b1, words[5], 1'b1);
    applyStimulus(8'h00, 1'b0, "er_idle", 8'h00, 3'd5, 1'b0, words[5], 1'b0);

    // Pointer now sits at 6; owner 6 then releases and the search wraps to 0.
    applyStimulus(8'h41, 1'b0, "wrap_gnt6", 8'h40, 3'd6, 1'b1, words[5], 1'b0);
    applyStimulus(8'h41, 1'b0, "wrap_hold6", 8'h40, 3'd6, 1'b1, words[6], 1'b1);
    applyStimulus(8'h01, 1'b0, "wrap_to0", 8'h01, 3'd0, 1'b1, words[6], 1'b0);
    applyStimulus(8'h01, 1'b0, "wrap_data0", 8'h01, 3'd0, 1'b1, words[0], 1'b1);
    applyStimulus(8'h00, 1'b0, "wrap_idle", 8'h00, 3'd0, 1'b0, words[0], 1'b0);

    // Reset during the second grant cycle of owner 4.
    applyStimulus(8'h10, 1'b0, "mid_gnt4", 8'h10, 3'd4, 1'b1, words[0], 1'b0);
    applyStimulus(8'h10, 1'b0, "mid_cyc2", 8'h10, 3'd4, 1'b1, words[4], 1'b1);
    applyStimulus(8'h11, 1'b1, "mid_reset", 8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(8'h11, 1'b0, "post_gnt0", 8'h01, 3'd0, 1'b1, words[0], 1'b0);
    applyStimulus(8'h11, 1'b0, "post_data0", 8'h01, 3'd0, 1'b1, words[0], 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
